// File: rtl/jzjpcc_lsu_sequencer.sv
// Load/store sequencer between execute and memory: one request at a time, lane-aligned
// bus beats (split in two when an access crosses a bus word), extended load results.
module jzjpcc_lsu_sequencer #(
   parameter int XLEN             = 32,
   parameter int ALLOW_MISALIGNED = 1
) (
   input  logic                            clock,
   input  logic                            reset_n,
   input  logic                            req_valid,
   output logic                            req_ready,
   input  logic                            req_isStore,
   input  logic [2:0]                      req_funct3,
   input  logic [XLEN-1:0]                 req_rs1,
   input  logic [XLEN-1:0]                 req_immediate,
   input  logic [XLEN-1:0]                 req_rs2,
   input  logic [4:0]                      req_rdIndex,
   output logic                            mem_valid,
   input  logic                            mem_ready,
   output logic                            mem_write,
   output logic [XLEN-$clog2(XLEN/8)-1:0]  mem_address,
   output logic [XLEN/8-1:0]               mem_byteMask,
   output logic [XLEN-1:0]                 mem_writeData,
   input  logic                            mem_readValid,
   input  logic [XLEN-1:0]                 mem_readData,
   output logic                            resp_valid,
   output logic                            resp_fault,
   output logic [XLEN-1:0]                 resp_data,
   output logic [4:0]                      resp_rdIndex
);

   localparam int BYTES = XLEN / 8;
   localparam int OFS   = $clog2(BYTES);
   localparam int AW    = XLEN - OFS;

   localparam logic [2*BYTES-1:0] MASK_ONE = 1;
   localparam logic [AW-1:0]      ADDR_ONE = 1;

   typedef enum logic [2:0] {
      S_IDLE, S_BEAT0, S_WAIT0, S_BEAT1, S_WAIT1, S_DONE, S_FAULT
   } state_t;

   state_t            state_q, state_d;
   logic              store_q, store_d;
   logic [2:0]        funct3_q, funct3_d;
   logic [4:0]        rd_q, rd_d;
   logic [OFS-1:0]    ofs_q, ofs_d;
   logic              cross_q, cross_d;
   logic [BYTES-1:0]  b1_mask_q, b1_mask_d;
   logic [XLEN-1:0]   b1_data_q, b1_data_d;
   logic [XLEN-1:0]   low_q, low_d;
   logic              mem_valid_q, mem_valid_d;
   logic              mem_write_q, mem_write_d;
   logic [AW-1:0]     mem_addr_q, mem_addr_d;
   logic [BYTES-1:0]  mem_mask_q, mem_mask_d;
   logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;
   logic [XLEN-1:0]   resp_data_q, resp_data_d;

   logic [XLEN-1:0]     ea;
   logic [OFS-1:0]      ofs_in;
   logic [3:0]          nbytes;
   logic                crossing;
   logic                misaligned;
   logic                illegal;
   logic                fault;
   logic [2*BYTES-1:0]  mask_wide;
   logic [2*XLEN-1:0]   data_wide;

   function automatic logic [XLEN-1:0] extend_load(input logic [XLEN-1:0] raw,
                                                   input logic [1:0] size,
                                                   input logic uns);
      int              nbits;
      logic            sgn;
      logic [XLEN-1:0] r;
      nbits = 8 << size;
      case (size)
         2'd0:    sgn = raw[7];
         2'd1:    sgn = raw[15];
         2'd2:    sgn = raw[31];
         default: sgn = raw[XLEN-1];
      endcase
      if (uns) sgn = 1'b0;
      for (int i = 0; i < XLEN; i++) r[i] = (i < nbits) ? raw[i] : sgn;
      return r;
   endfunction

   // Beat0 lanes start at the access offset; beat1 lanes continue from lane 0.
   function automatic logic [XLEN-1:0] assemble_load(input logic [XLEN-1:0] lo,
                                                     input logic [XLEN-1:0] hi,
                                                     input logic [OFS-1:0]  ofs,
                                                     input logic [2:0]      f3);
      logic [2*XLEN-1:0] wide;
      wide = {hi, lo} >> {ofs, 3'b000};
      return extend_load(wide[XLEN-1:0], f3[1:0], f3[2]);
   endfunction

   always_comb begin
      ea       = req_rs1 + req_immediate;
      ofs_in   = ea[OFS-1:0];
      nbytes   = 4'd1 << req_funct3[1:0];
      crossing = (int'(ofs_in) + int'(nbytes)) > BYTES;
      case (req_funct3[1:0])
         2'd0:    misaligned = 1'b0;
         2'd1:    misaligned = ofs_in[0];
         2'd2:    misaligned = |ofs_in[1:0];
         default: misaligned = |ofs_in;
      endcase
      illegal   = (XLEN == 32) && (req_funct3[1:0] == 2'b11);
      fault     = illegal || ((ALLOW_MISALIGNED == 0) && misaligned);
      mask_wide = ((MASK_ONE << nbytes) - MASK_ONE) << ofs_in;
      data_wide = {{XLEN{1'b0}}, req_rs2} << {ofs_in, 3'b000};
   end

   always_comb begin
      state_d     = state_q;
      store_d     = store_q;
      funct3_d    = funct3_q;
      rd_d        = rd_q;
      ofs_d       = ofs_q;
      cross_d     = cross_q;
      b1_mask_d   = b1_mask_q;
      b1_data_d   = b1_data_q;
      low_d       = low_q;
      mem_valid_d = mem_valid_q;
      mem_write_d = mem_write_q;
      mem_addr_d  = mem_addr_q;
      mem_mask_d  = mem_mask_q;
      mem_wdata_d = mem_wdata_q;
      resp_data_d = '0;

      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               store_d   = req_isStore;
               funct3_d  = req_funct3;
               rd_d      = req_rdIndex;
               ofs_d     = ofs_in;
               cross_d   = crossing;
               b1_mask_d = mask_wide[2*BYTES-1:BYTES];
               b1_data_d = data_wide[2*XLEN-1:XLEN];
               low_d     = '0;
               if (fault) begin
                  state_d = S_FAULT;
               end else begin
                  state_d     = S_BEAT0;
                  mem_valid_d = 1'b1;
                  mem_write_d = req_isStore;
                  mem_addr_d  = ea[XLEN-1:OFS];
                  mem_mask_d  = mask_wide[BYTES-1:0];
                  mem_wdata_d = data_wide[XLEN-1:0];
               end
            end
         end
         S_BEAT0: begin
            if (mem_ready) begin
               if (store_q && cross_q) begin
                  state_d     = S_BEAT1;
                  mem_addr_d  = mem_addr_q + ADDR_ONE;
                  mem_mask_d  = b1_mask_q;
                  mem_wdata_d = b1_data_q;
               end else begin
                  state_d     = store_q ? S_DONE : S_WAIT0;
                  mem_valid_d = 1'b0;
                  mem_write_d = 1'b0;
                  mem_mask_d  = '0;
                  mem_wdata_d = '0;
               end
            end
         end
         S_WAIT0: begin
            if (mem_readValid) begin
               low_d = mem_readData;
               if (cross_q) begin
                  state_d     = S_BEAT1;
                  mem_valid_d = 1'b1;
                  mem_write_d = 1'b0;
                  mem_addr_d  = mem_addr_q + ADDR_ONE;
                  mem_mask_d  = b1_mask_q;
                  mem_wdata_d = b1_data_q;
               end else begin
                  state_d     = S_DONE;
                  resp_data_d = assemble_load(mem_readData, '0, ofs_q, funct3_q);
               end
            end
         end
         S_BEAT1: begin
            if (mem_ready) begin
               state_d     = store_q ? S_DONE : S_WAIT1;
               mem_valid_d = 1'b0;
               mem_write_d = 1'b0;
               mem_mask_d  = '0;
               mem_wdata_d = '0;
            end
         end
         S_WAIT1: begin
            if (mem_readValid) begin
               state_d     = S_DONE;
               resp_data_d = assemble_load(low_q, mem_readData, ofs_q, funct3_q);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         store_q     <= 1'b0;
         funct3_q    <= '0;
         rd_q        <= '0;
         ofs_q       <= '0;
         cross_q     <= 1'b0;
         b1_mask_q   <= '0;
         b1_data_q   <= '0;
         low_q       <= '0;
         mem_valid_q <= 1'b0;
         mem_write_q <= 1'b0;
         mem_addr_q  <= '0;
         mem_mask_q  <= '0;
         mem_wdata_q <= '0;
         resp_data_q <= '0;
      end else begin
         state_q     <= state_d;
         store_q     <= store_d;
         funct3_q    <= funct3_d;
         rd_q        <= rd_d;
         ofs_q       <= ofs_d;
         cross_q     <= cross_d;
         b1_mask_q   <= b1_mask_d;
         b1_data_q   <= b1_data_d;
         low_q       <= low_d;
         mem_valid_q <= mem_valid_d;
         mem_write_q <= mem_write_d;
         mem_addr_q  <= mem_addr_d;
         mem_mask_q  <= mem_mask_d;
         mem_wdata_q <= mem_wdata_d;
         resp_data_q <= resp_data_d;
      end
   end

   assign req_ready     = (state_q == S_IDLE);
   assign mem_valid     = mem_valid_q;
   assign mem_write     = mem_write_q;
   assign mem_address   = mem_addr_q;
   assign mem_byteMask  = mem_mask_q;
   assign mem_writeData = mem_wdata_q;
   assign resp_valid    = (state_q == S_DONE) || (state_q == S_FAULT);
   assign resp_fault    = (state_q == S_FAULT);
   assign resp_data     = resp_data_q;
   assign resp_rdIndex  = rd_q;

endmodule

// File: tb/tb_jzjpcc_lsu_sequencer.sv
// Directed scoreboard bench: three sequencer configurations (32/misaligned-ok, 64/misaligned-ok,
// 32/strict) share one stimulus path; expected beats and responses are queued per request.
module tb_jzjpcc_lsu_sequencer;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic        reset_n;
   int          sel;
   logic        req_valid, req_isStore;
   logic [2:0]  req_funct3;
   logic [63:0] req_rs1, req_immediate, req_rs2;
   logic [4:0]  req_rdIndex;
   logic        mem_ready, mem_readValid;
   logic [63:0] mem_readData;

   logic a_req_ready, a_mem_valid, a_mem_write, a_resp_valid, a_resp_fault;
   logic [29:0] a_mem_address;
   logic [3:0]  a_mem_byteMask;
   logic [31:0] a_mem_writeData, a_resp_data;
   logic [4:0]  a_resp_rdIndex;

   logic b_req_ready, b_mem_valid, b_mem_write, b_resp_valid, b_resp_fault;
   logic [60:0] b_mem_address;
   logic [7:0]  b_mem_byteMask;
   logic [63:0] b_mem_writeData, b_resp_data;
   logic [4:0]  b_resp_rdIndex;

   logic c_req_ready, c_mem_valid, c_mem_write, c_resp_valid, c_resp_fault;
   logic [29:0] c_mem_address;
   logic [3:0]  c_mem_byteMask;
   logic [31:0] c_mem_writeData, c_resp_data;
   logic [4:0]  c_resp_rdIndex;

   logic        o_req_ready, o_mem_valid, o_mem_write, o_resp_valid, o_resp_fault;
   logic [63:0] o_mem_address, o_mem_writeData, o_resp_data;
   logic [7:0]  o_mem_byteMask;
   logic [4:0]  o_resp_rdIndex;

   jzjpcc_lsu_sequencer #(.XLEN(32), .ALLOW_MISALIGNED(1)) u_a (
      .clock(clock), .reset_n(reset_n),
      .req_valid(req_valid && (sel == 0)), .req_ready(a_req_ready),
      .req_isStore(req_isStore), .req_funct3(req_funct3),
      .req_rs1(req_rs1[31:0]), .req_immediate(req_immediate[31:0]),
      .req_rs2(req_rs2[31:0]), .req_rdIndex(req_rdIndex),
      .mem_valid(a_mem_valid), .mem_ready(mem_ready && (sel == 0)),
      .mem_write(a_mem_write), .mem_address(a_mem_address),
      .mem_byteMask(a_mem_byteMask), .mem_writeData(a_mem_writeData),
      .mem_readValid(mem_readValid && (sel == 0)), .mem_readData(mem_readData[31:0]),
      .resp_valid(a_resp_valid), .resp_fault(a_resp_fault),
      .resp_data(a_resp_data), .resp_rdIndex(a_resp_rdIndex));

   jzjpcc_lsu_sequencer #(.XLEN(64), .ALLOW_MISALIGNED(1)) u_b (
      .clock(clock), .reset_n(reset_n),
      .req_valid(req_valid && (sel == 1)), .req_ready(b_req_ready),
      .req_isStore(req_isStore), .req_funct3(req_funct3),
      .req_rs1(req_rs1), .req_immediate(req_immediate),
      .req_rs2(req_rs2), .req_rdIndex(req_rdIndex),
      .mem_valid(b_mem_valid), .mem_ready(mem_ready && (sel == 1)),
      .mem_write(b_mem_write), .mem_address(b_mem_address),
      .mem_byteMask(b_mem_byteMask), .mem_writeData(b_mem_writeData),
      .mem_readValid(mem_readValid && (sel == 1)), .mem_readData(mem_readData),
      .resp_valid(b_resp_valid), .resp_fault(b_resp_fault),
      .resp_data(b_resp_data), .resp_rdIndex(b_resp_rdIndex));

   jzjpcc_lsu_sequencer #(.XLEN(32), .ALLOW_MISALIGNED(0)) u_c (
      .clock(clock), .reset_n(reset_n),
      .req_valid(req_valid && (sel == 2)), .req_ready(c_req_ready),
      .req_isStore(req_isStore), .req_funct3(req_funct3),
      .req_rs1(req_rs1[31:0]), .req_immediate(req_immediate[31:0]),
      .req_rs2(req_rs2[31:0]), .req_rdIndex(req_rdIndex),
      .mem_valid(c_mem_valid), .mem_ready(mem_ready && (sel == 2)),
      .mem_write(c_mem_write), .mem_address(c_mem_address),
      .mem_byteMask(c_mem_byteMask), .mem_writeData(c_mem_writeData),
      .mem_readValid(mem_readValid && (sel == 2)), .mem_readData(mem_readData[31:0]),
      .resp_valid(c_resp_valid), .resp_fault(c_resp_fault),
      .resp_data(c_resp_data), .resp_rdIndex(c_resp_rdIndex));

   always_comb begin
      o_req_ready     = a_req_ready;
      o_mem_valid     = a_mem_valid;
      o_mem_write     = a_mem_write;
      o_mem_address   = 64'(a_mem_address);
      o_mem_byteMask  = 8'(a_mem_byteMask);
      o_mem_writeData = 64'(a_mem_writeData);
      o_resp_valid    = a_resp_valid;
      o_resp_fault    = a_resp_fault;
      o_resp_data     = 64'(a_resp_data);
      o_resp_rdIndex  = a_resp_rdIndex;
      if (sel == 1) begin
         o_req_ready     = b_req_ready;
         o_mem_valid     = b_mem_valid;
         o_mem_write     = b_mem_write;
         o_mem_address   = 64'(b_mem_address);
         o_mem_byteMask  = b_mem_byteMask;
         o_mem_writeData = b_mem_writeData;
         o_resp_valid    = b_resp_valid;
         o_resp_fault    = b_resp_fault;
         o_resp_data     = b_resp_data;
         o_resp_rdIndex  = b_resp_rdIndex;
      end else if (sel == 2) begin
         o_req_ready     = c_req_ready;
         o_mem_valid     = c_mem_valid;
         o_mem_write     = c_mem_write;
         o_mem_address   = 64'(c_mem_address);
         o_mem_byteMask  = 8'(c_mem_byteMask);
         o_mem_writeData = 64'(c_mem_writeData);
         o_resp_valid    = c_resp_valid;
         o_resp_fault    = c_resp_fault;
         o_resp_data     = 64'(c_resp_data);
         o_resp_rdIndex  = c_resp_rdIndex;
      end
   end

   typedef struct {
      logic [63:0] addr;
      logic [7:0]  mask;
      logic        wr;
      logic [63:0] wdata;
      logic [63:0] rdata;
   } beat_t;

   typedef struct {
      logic        fault;
      logic [63:0] data;
      logic [4:0]  rd;
      int          lat;
   } resp_t;

   beat_t beat_q[$];
   resp_t resp_q[$];
   int    vectors;
   int    miscompares;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push_beat(input logic [63:0] addr, input logic [7:0] mask, input logic wr,
                            input logic [63:0] wdata, input logic [63:0] rdata);
      beat_t b;
      b.addr  = addr;
      b.mask  = mask;
      b.wr    = wr;
      b.wdata = wdata;
      b.rdata = rdata;
      beat_q.push_back(b);
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_req_ready"}, 64'(o_req_ready), 64'd1);
      check({tag, "_mem_valid"}, 64'(o_mem_valid), 64'd0);
      check({tag, "_mem_write"}, 64'(o_mem_write), 64'd0);
      check({tag, "_mem_address"}, o_mem_address, 64'd0);
      check({tag, "_mem_byteMask"}, 64'(o_mem_byteMask), 64'd0);
      check({tag, "_mem_writeData"}, o_mem_writeData, 64'd0);
      check({tag, "_resp_valid"}, 64'(o_resp_valid), 64'd0);
      check({tag, "_resp_fault"}, 64'(o_resp_fault), 64'd0);
      check({tag, "_resp_data"}, o_resp_data, 64'd0);
      check({tag, "_resp_rdIndex"}, 64'(o_resp_rdIndex), 64'd0);
   endtask

   // Drives one request to instance s and services the bus until the response (or abort).
   task automatic run_req(input int s, input logic st, input logic [2:0] f3,
                          input logic [63:0] rs1, input logic [63:0] imm, input logic [63:0] rs2,
                          input logic [4:0] rd, input logic fault, input logic [63:0] data,
                          input int lat, input int stall0, input bit abort);
      resp_t       r;
      beat_t       b;
      int          cyc, nbeat, stall;
      bit          active, pend, got;
      logic [63:0] pend_data, h_addr, h_wdata;
      logic [7:0]  h_mask;
      logic        h_write;
      @(negedge clock);
      sel = s;
      #1;
      check("req_ready_idle", 64'(o_req_ready), 64'd1);
      req_valid     = 1'b1;
      req_isStore   = st;
      req_funct3    = f3;
      req_rs1       = rs1;
      req_immediate = imm;
      req_rs2       = rs2;
      req_rdIndex   = rd;
      if (!abort) begin
         r.fault = fault;
         r.data  = data;
         r.rd    = rd;
         r.lat   = lat;
         resp_q.push_back(r);
      end
      @(negedge clock);
      req_valid = 1'b0;
      cyc = 1; nbeat = 0; stall = stall0;
      active = 0; pend = 0; got = 0;
      pend_data = '0; h_addr = '0; h_wdata = '0; h_mask = '0; h_write = 1'b0;
      b = '{default: '0};
      while (!got && cyc < 40) begin
         mem_ready     = 1'b0;
         mem_readValid = 1'b0;
         if (abort && pend && nbeat == 2) begin
            reset_n = 1'b0;
            #1;
            check_idle_outputs("async_reset");
            @(posedge clock);
            @(negedge clock);
            reset_n = 1'b1;
            for (int k = 0; k < 4; k++) begin
               @(negedge clock);
               check("post_reset_no_resp", 64'(o_resp_valid), 64'd0);
               check("post_reset_no_beat", 64'(o_mem_valid), 64'd0);
            end
            pend = 0;
            got  = 1;
         end else begin
            if (pend) begin
               mem_readValid = 1'b1;
               mem_readData  = pend_data;
               pend          = 0;
            end
            if (o_resp_valid) begin
               got = 1;
               if (resp_q.size() == 0) begin
                  check("unexpected_resp", 64'd1, 64'd0);
               end else begin
                  r = resp_q.pop_front();
                  check("resp_fault", 64'(o_resp_fault), 64'(r.fault));
                  check("resp_data", o_resp_data, r.data);
                  check("resp_rdIndex", 64'(o_resp_rdIndex), 64'(r.rd));
                  check("resp_latency", 64'(cyc), 64'(r.lat));
               end
            end else if (o_mem_valid) begin
               if (!active) begin
                  if (beat_q.size() == 0) begin
                     b = '{default: '0};
                     check("unexpected_beat", 64'd1, 64'd0);
                  end else begin
                     b = beat_q.pop_front();
                     check("beat_address", o_mem_address, b.addr);
                     check("beat_byteMask", 64'(o_mem_byteMask), 64'(b.mask));
                     check("beat_write", 64'(o_mem_write), 64'(b.wr));
                     if (b.wr) check("beat_writeData", o_mem_writeData, b.wdata);
                  end
                  h_addr = o_mem_address; h_mask = o_mem_byteMask;
                  h_wdata = o_mem_writeData; h_write = o_mem_write;
                  active = 1;
               end else begin
                  check("hold_address", o_mem_address, h_addr);
                  check("hold_byteMask", 64'(o_mem_byteMask), 64'(h_mask));
                  check("hold_writeData", o_mem_writeData, h_wdata);
                  check("hold_write", 64'(o_mem_write), 64'(h_write));
               end
               if (stall > 0) begin
                  stall--;
               end else begin
                  mem_ready = 1'b1;
                  active    = 0;
                  nbeat++;
                  if (!o_mem_write) begin
                     pend      = 1;
                     pend_data = b.rdata;
                  end
               end
            end
            if (!got) begin
               @(negedge clock);
               cyc++;
            end
         end
      end
      mem_ready     = 1'b0;
      mem_readValid = 1'b0;
      if (!got) check("response_timeout", 64'd0, 64'd1);
      check("beats_outstanding", 64'(beat_q.size()), 64'd0);
      beat_q.delete();
   endtask

   initial begin
      vectors = 0; miscompares = 0; sel = 0;
      reset_n = 1'b0; req_valid = 1'b0; req_isStore = 1'b0; req_funct3 = '0;
      req_rs1 = '0; req_immediate = '0; req_rs2 = '0; req_rdIndex = '0;
      mem_ready = 1'b0; mem_readValid = 1'b0; mem_readData = '0;
      repeat (2) @(negedge clock);
      for (int s = 0; s < 3; s++) begin
         sel = s;
         #1;
         check_idle_outputs("reset");
      end
      sel = 0;
      reset_n = 1'b1;

      // XLEN=32, misaligned allowed
      push_beat(64'h401, 8'hF, 1'b0, 64'h0, 64'h80FF_1234);
      run_req(0, 1'b0, 3'b010, 64'h1000, 64'h4, 64'h0, 5'd7, 1'b0, 64'h80FF_1234, 3, 0, 1'b0);
      push_beat(64'h800, 8'h8, 1'b1, 64'hAB00_0000, 64'h0);
      run_req(0, 1'b1, 3'b000, 64'h2000, 64'h3, 64'hAB, 5'd3, 1'b0, 64'h0, 2, 0, 1'b0);
      push_beat(64'h0, 8'h8, 1'b0, 64'h0, 64'h7F00_0000);
      push_beat(64'h1, 8'h1, 1'b0, 64'h0, 64'h0000_0080);
      run_req(0, 1'b0, 3'b001, 64'h10, 64'hFFFF_FFF3, 64'h0, 5'd12, 1'b0, 64'hFFFF_807F, 5, 0, 1'b0);
      push_beat(64'h0, 8'h8, 1'b0, 64'h0, 64'h7F00_0000);
      push_beat(64'h1, 8'h1, 1'b0, 64'h0, 64'h0000_0080);
      run_req(0, 1'b0, 3'b101, 64'h3, 64'h0, 64'h0, 5'd13, 1'b0, 64'h0000_807F, 5, 0, 1'b0);
      push_beat(64'h40, 8'h2, 1'b0, 64'h0, 64'h0000_8500);
      run_req(0, 1'b0, 3'b000, 64'h100, 64'h1, 64'h0, 5'd4, 1'b0, 64'hFFFF_FF85, 3, 0, 1'b0);
      push_beat(64'h40, 8'h2, 1'b0, 64'h0, 64'h0000_8500);
      run_req(0, 1'b0, 3'b100, 64'h100, 64'h1, 64'h0, 5'd5, 1'b0, 64'h0000_0085, 3, 0, 1'b0);
      push_beat(64'h1, 8'hC, 1'b1, 64'h3344_0000, 64'h0);
      push_beat(64'h2, 8'h3, 1'b1, 64'h0000_1122, 64'h0);
      run_req(0, 1'b1, 3'b010, 64'h6, 64'h0, 64'h1122_3344, 5'd9, 1'b0, 64'h0, 3, 0, 1'b0);
      run_req(0, 1'b0, 3'b011, 64'h8, 64'h0, 64'h0, 5'd21, 1'b1, 64'h0, 1, 0, 1'b0);

      // XLEN=32, misaligned faults
      run_req(2, 1'b0, 3'b010, 64'h2, 64'h0, 64'h0, 5'd6, 1'b1, 64'h0, 1, 0, 1'b0);
      push_beat(64'h0, 8'hC, 1'b0, 64'h0, 64'hBEEF_0000);
      run_req(2, 1'b0, 3'b001, 64'h2, 64'h0, 64'h0, 5'd8, 1'b0, 64'hFFFF_BEEF, 3, 0, 1'b0);
      run_req(2, 1'b0, 3'b001, 64'h1, 64'h0, 64'h0, 5'd10, 1'b1, 64'h0, 1, 0, 1'b0);
      run_req(2, 1'b1, 3'b011, 64'h0, 64'h0, 64'h55, 5'd11, 1'b1, 64'h0, 1, 0, 1'b0);

      // XLEN=64
      push_beat(64'h1FFF_FFFF_FFFF_FFFF, 8'hF0, 1'b1, 64'h0506_0708_0000_0000, 64'h0);
      push_beat(64'h0, 8'h0F, 1'b1, 64'h0000_0000_0102_0304, 64'h0);
      run_req(1, 1'b1, 3'b011, 64'hFFFF_FFFF_FFFF_FFF0, 64'hC, 64'h0102_0304_0506_0708, 5'd14,
              1'b0, 64'h0, 6, 3, 1'b0);
      push_beat(64'h0, 8'hF0, 1'b0, 64'h0, 64'h8000_0001_0000_0000);
      run_req(1, 1'b0, 3'b010, 64'h4, 64'h0, 64'h0, 5'd15, 1'b0, 64'hFFFF_FFFF_8000_0001, 3, 0, 1'b0);
      push_beat(64'h0, 8'hF0, 1'b0, 64'h0, 64'h8000_0001_0000_0000);
      run_req(1, 1'b0, 3'b110, 64'h4, 64'h0, 64'h0, 5'd16, 1'b0, 64'h0000_0000_8000_0001, 3, 0, 1'b0);
      push_beat(64'h2, 8'hFF, 1'b0, 64'h0, 64'h1234_5678_9ABC_DEF0);
      run_req(1, 1'b0, 3'b011, 64'h8, 64'h8, 64'h0, 5'd17, 1'b0, 64'h1234_5678_9ABC_DEF0, 3, 0, 1'b0);

      // Reset while waiting for the second read beat, then a normal request
      push_beat(64'h0, 8'h8, 1'b0, 64'h0, 64'h7F00_0000);
      push_beat(64'h1, 8'h1, 1'b0, 64'h0, 64'h0000_0080);
      run_req(0, 1'b0, 3'b001, 64'h3, 64'h0, 64'h0, 5'd18, 1'b0, 64'h0, 0, 0, 1'b1);
      check("resp_queue_after_abort", 64'(resp_q.size()), 64'd0);
      push_beat(64'h401, 8'hF, 1'b0, 64'h0, 64'h0BAD_F00D);
      run_req(0, 1'b0, 3'b010, 64'h1000, 64'h4, 64'h0, 5'd19, 1'b0, 64'h0BAD_F00D, 3, 0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/jzjpcc_lsu_sequencer.md
Name: jzjpcc_lsu_sequencer

Overview:
Parametrised load/store sequencer for the execute/memory boundary of the pipelined core. It is the successor to the single-cycle memory address/mask/data generator.
- Accepts one load or store request via valid/ready.
- Computes the effective address, byte-lane mask and write-data alignment for XLEN-wide buses.
- Splits misaligned accesses into two bus beats.
- Assembles and sign/zero-extends load results.
- Returns one completion per request to writeback.

Parameters:
XLEN, 32, datapath and bus width; legal values 32 or 64; BYTES = XLEN/8, OFS = log2(BYTES).
ALLOW_MISALIGNED, 1, 1 = split lane-crossing accesses into two beats; 0 = report them as faults with no bus activity.

Ports:
clock  input  1  core clock; all state updates on the rising edge.
reset_n  input  1  asynchronous active-low reset.
req_valid  input  1  request offered.
req_ready  output  1  high only in IDLE.
req_isStore  input  1  1 = store, 0 = load.
req_funct3  input  3  RISC-V funct3; [1:0] = size (00 B, 01 H, 10 W, 11 D); [2] = unsigned load.
req_rs1  input  XLEN  base address.
req_immediate  input  XLEN  sign-extended offset.
req_rs2  input  XLEN  store data.
req_rdIndex  input  5  load destination register, returned with the response.
mem_valid  output  1  bus beat offered.
mem_ready  input  1  bus accepts beat.
mem_write  output  1  beat is a write.
mem_address  output  XLEN-OFS  word address.
mem_byteMask  output  BYTES  lane enables; bit i = byte offset i within the word.
mem_writeData  output  XLEN  lane-aligned write data; byte i at bits [8i+7:8i].
mem_readValid  input  1  read data for the oldest accepted read beat.
mem_readData  input  XLEN  read data, same lane convention.
resp_valid  output  1  one-cycle completion pulse.
resp_fault  output  1  misaligned-with-ALLOW_MISALIGNED=0 or illegal size.
resp_data  output  XLEN  extended load result; 0 for stores and faults.
resp_rdIndex  output  5  captured req_rdIndex.

Behaviour:
- Clock/reset: one clock domain (clock). reset_n is asynchronous and active-low; its deassertion is synchronised externally.
- Reset (asynchronous, any state):
  - State goes to IDLE and all captured registers clear.
  - mem_valid, mem_write, mem_byteMask, mem_address, mem_writeData, resp_* are 0.
  - req_ready is 1.
  - An in-flight request is abandoned; no response is issued.
- Address: ea = rs1 + immediate, modulo 2^XLEN; ofs = ea[OFS-1:0]; size bytes n = 1 << funct3[1:0].
- Illegal size: funct3[1:0]=11 when XLEN=32 -> fault.
- Crossing: the access crosses a word when ofs + n > BYTES.
  - ALLOW_MISALIGNED=0: any ofs not a multiple of n -> fault (even if not crossing).
  - ALLOW_MISALIGNED=1: only illegal size faults.
- FSM states:
  - IDLE: req_ready=1; on req_valid, capture the request; go to FAULT if it faults, else BEAT0.
  - BEAT0: mem_valid=1, address ea[XLEN-1:OFS], mask lanes ofs..min(ofs+n,BYTES)-1, data = rs2 shifted left by 8*ofs and truncated to XLEN. On mem_ready:
    - store crossing -> BEAT1.
    - store not crossing -> DONE.
    - load -> WAIT0.
  - WAIT0: on mem_readValid, latch the low part. Go to BEAT1 if crossing, else DONE.
  - BEAT1: address = beat0 address + 1, wrapping modulo 2^(XLEN-OFS); mask lanes 0..ofs+n-BYTES-1; data = rs2 >> 8*(BYTES-ofs). On mem_ready: load -> WAIT1, store -> DONE.
  - WAIT1: on mem_readValid, latch the high part, then DONE.
  - DONE: resp_valid=1 for one cycle, then IDLE.
  - FAULT: resp_valid=1, resp_fault=1 for one cycle, then IDLE.
- Load assembly: bytes are taken from the beat0 lanes ofs.. upward, then the beat1 lanes from 0, giving n bytes. Sign-extend from bit 8n-1 unless funct3[2]=1; for W on XLEN=64, funct3[2]=1 selects LWU.
- Bus hold: all mem_* outputs are registered and remain stable while mem_valid && !mem_ready.
- mem_readValid outside WAIT0/WAIT1 is ignored.
- Latency with no stalls:
  - aligned store: response 2 cycles after accept.
  - aligned load with readValid one cycle after the beat: response 3 cycles after accept.
  - each split adds 1 cycle (store) or 2 cycles (load).
  - fault: response 1 cycle after accept.
- One request is outstanding at a time. A new request is accepted in the IDLE cycle that follows DONE/FAULT (throughput: 1 request per (latency+1) cycles).

Test Plan:
1. XLEN=32: LW at rs1=0x1000, imm=4 -> one beat, addr 0x401, mask 1111; readData 0x80FF_1234 -> resp_data 0x80FF_1234, resp_rdIndex echoed.
2. XLEN=32: SB rs2=0xAB, ea=0x2003 -> mask 1000, writeData 0xAB00_0000, single beat, resp_data 0.
3. XLEN=32, ALLOW_MISALIGNED=1: LH ea=0x0003 -> beat0 addr 0 mask 1000, readData 0x7F00_0000; beat1 addr 1 mask 0001, readData 0x0000_0080 -> resp_data 0xFFFF_807F; same access with LHU -> 0x0000_807F.
4. XLEN=64: SD ea=0xFFFF_FFFF_FFFF_FFFC -> beat0 mask 0xF0, beat1 address wraps to 0 with mask 0x0F; hold mem_ready low 3 cycles on beat0 -> all mem_* outputs stable throughout.
5. ALLOW_MISALIGNED=0: LW ea=0x0002 -> no mem_valid, resp_valid+resp_fault the next cycle; XLEN=32 with funct3=011 -> fault.
6. Assert reset_n low during WAIT1 -> outputs cleared immediately, req_ready=1, no response; the next request completes normally.
